// File: rtl/poly_voice_allocator.sv
// Polyphonic MIDI voice allocator: decodes note events onto POLYPHONY voices with
// same-note retrigger and least-recently-allocated stealing.
module poly_voice_allocator #(
   parameter int POLYPHONY    = 8,
   parameter int VIDX_W       = 3,
   parameter int FREQ_W       = 32,
   parameter int RETRIG_GAP   = 2,
   parameter int MIDI_CHANNEL = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        midi_byte_ready,
   input  logic [7:0]                  midi_byte0,
   input  logic [7:0]                  midi_byte1,
   input  logic [7:0]                  midi_byte2,
   input  logic                        omni,
   output logic [POLYPHONY*FREQ_W-1:0] dds_frequency_bus,
   output logic [POLYPHONY*7-1:0]      voice_velocity,
   output logic [POLYPHONY-1:0]        key_state,
   output logic                        busy,
   output logic                        dropped_event
);

   localparam int GAP_W = $clog2(RETRIG_GAP + 1);

   typedef enum logic [1:0] {IDLE, SEARCH, APPLY, GAP} state_t;
   typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF, EV_ALL} event_t;

   state_t               state, state_n;
   event_t               ev_dec, ev_r;
   logic [6:0]           note_r, vel_r;
   logic [6:0]           voice_note [POLYPHONY];
   logic [POLYPHONY-1:0] voice_held;
   logic [VIDX_W-1:0]    age [POLYPHONY];
   logic                 match_hit, free_hit, match_hit_r, free_hit_r;
   logic [VIDX_W-1:0]    match_v, free_v, oldest_v;
   logic [VIDX_W-1:0]    match_v_r, free_v_r, oldest_v_r, target, gap_v;
   logic                 need_gap;
   logic [GAP_W-1:0]     gap_cnt;

   // Top-octave (notes 120..131) tuning words; lower octaves are right shifts.
   function automatic logic [FREQ_W-1:0] tuning_code_lookup(input logic [6:0] note);
      int          n;
      logic [31:0] base;
      n = int'(note);
      case (n % 12)
         0:       base = 32'd719160;
         1:       base = 32'd761923;
         2:       base = 32'd807229;
         3:       base = 32'd855228;
         4:       base = 32'd906083;
         5:       base = 32'd959963;
         6:       base = 32'd1017046;
         7:       base = 32'd1077524;
         8:       base = 32'd1141599;
         9:       base = 32'd1209486;
         10:      base = 32'd1281408;
         default: base = 32'd1357607;
      endcase
      return FREQ_W'(base >> (10 - n / 12));
   endfunction

   assign busy          = (state != IDLE);
   assign dropped_event = midi_byte_ready && busy;

   always_comb begin
      ev_dec = EV_NONE;
      if (omni || (midi_byte0[3:0] == 4'(MIDI_CHANNEL))) begin
         case (midi_byte0[7:4])
            4'h9:    ev_dec = (midi_byte2 != 8'd0) ? EV_ON : EV_OFF;
            4'h8:    ev_dec = EV_OFF;
            4'hB:    if (midi_byte1 == 8'd120 || midi_byte1 == 8'd123) ev_dec = EV_ALL;
            default: ev_dec = EV_NONE;
         endcase
      end
   end

   // Descending scan so the lowest matching index wins.
   always_comb begin
      match_hit = 1'b0;
      match_v   = '0;
      free_hit  = 1'b0;
      free_v    = '0;
      oldest_v  = '0;
      for (int v = POLYPHONY - 1; v >= 0; v--) begin
         if (voice_held[v] && voice_note[v] == note_r) begin
            match_hit = 1'b1;
            match_v   = VIDX_W'(v);
         end
         if (!voice_held[v]) begin
            free_hit = 1'b1;
            free_v   = VIDX_W'(v);
         end
         if (age[v] == VIDX_W'(POLYPHONY - 1)) oldest_v = VIDX_W'(v);
      end
   end

   always_comb begin
      if (match_hit_r)     target = match_v_r;
      else if (free_hit_r) target = free_v_r;
      else                 target = oldest_v_r;
      need_gap = match_hit_r || !free_hit_r || key_state[target];
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (midi_byte_ready && ev_dec != EV_NONE) state_n = SEARCH;
         SEARCH:  state_n = APPLY;
         APPLY:   state_n = (ev_r == EV_ON && need_gap) ? GAP : IDLE;
         GAP:     if (gap_cnt == GAP_W'(RETRIG_GAP - 1)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dds_frequency_bus <= '0;
         voice_velocity    <= '0;
         key_state         <= '0;
         voice_held        <= '0;
         ev_r              <= EV_NONE;
         note_r            <= '0;
         vel_r             <= '0;
         match_hit_r       <= 1'b0;
         free_hit_r        <= 1'b0;
         match_v_r         <= '0;
         free_v_r          <= '0;
         oldest_v_r        <= '0;
         gap_v             <= '0;
         gap_cnt           <= '0;
         for (int v = 0; v < POLYPHONY; v++) begin
            voice_note[v] <= '0;
            age[v]        <= VIDX_W'(POLYPHONY - 1 - v);
         end
      end else begin
         case (state)
            IDLE: begin
               if (midi_byte_ready && ev_dec != EV_NONE) begin
                  ev_r   <= ev_dec;
                  note_r <= midi_byte1[6:0];
                  vel_r  <= midi_byte2[6:0];
               end
            end
            SEARCH: begin
               match_hit_r <= match_hit;
               match_v_r   <= match_v;
               free_hit_r  <= free_hit;
               free_v_r    <= free_v;
               oldest_v_r  <= oldest_v;
            end
            APPLY: begin
               case (ev_r)
                  EV_ON: begin
                     dds_frequency_bus[int'(target)*FREQ_W +: FREQ_W] <= tuning_code_lookup(note_r);
                     voice_velocity[int'(target)*7 +: 7] <= vel_r;
                     voice_note[target] <= note_r;
                     voice_held[target] <= 1'b1;
                     for (int v = 0; v < POLYPHONY; v++)
                        if (age[v] < age[target]) age[v] <= age[v] + 1'b1;
                     age[target]       <= '0;
                     key_state[target] <= !need_gap;
                     gap_v             <= target;
                     gap_cnt           <= '0;
                  end
                  EV_OFF: begin
                     if (match_hit_r) begin
                        key_state[match_v_r]  <= 1'b0;
                        voice_held[match_v_r] <= 1'b0;
                     end
                  end
                  EV_ALL: begin
                     key_state  <= '0;
                     voice_held <= '0;
                  end
                  default: ;
               endcase
            end
            GAP: begin
               if (gap_cnt == GAP_W'(RETRIG_GAP - 1)) key_state[gap_v] <= 1'b1;
               else                                   gap_cnt <= gap_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Bench for poly_voice_allocator: event-level reference model with LRU timestamps,
// per-cycle comparison, directed scenarios and a randomized event stream.
module tb_poly_voice_allocator;

   localparam int POLY = 8;
   localparam int VW   = 3;
   localparam int FW   = 32;
   localparam int GAPC = 2;
   localparam int CH   = 0;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 ready = 1'b0;
   logic                 omni = 1'b0;
   logic [7:0]           b0 = 8'h00, b1 = 8'h00, b2 = 8'h00;
   logic [POLY*FW-1:0]   freq_bus;
   logic [POLY*7-1:0]    vel_bus;
   logic [POLY-1:0]      key;
   logic                 busy, dropped;

   poly_voice_allocator #(
      .POLYPHONY(POLY), .VIDX_W(VW), .FREQ_W(FW), .RETRIG_GAP(GAPC), .MIDI_CHANNEL(CH)
   ) dut (
      .clk(clk), .reset(reset), .midi_byte_ready(ready),
      .midi_byte0(b0), .midi_byte1(b1), .midi_byte2(b2), .omni(omni),
      .dds_frequency_bus(freq_bus), .voice_velocity(vel_bus), .key_state(key),
      .busy(busy), .dropped_event(dropped)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit armed = 1'b0;

   bit m_key [POLY];
   bit m_held[POLY];
   int m_note[POLY], m_freq[POLY], m_vel[POLY], m_stamp[POLY];
   int next_stamp;
   int rem, commit_in, rise_in;
   int p_ev, p_note, p_vel, p_tgt;
   bit p_gap;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lookup(input int n);
      int base;
      case (n % 12)
         0: base = 719160;   1: base = 761923;   2: base = 807229;   3: base = 855228;
         4: base = 906083;   5: base = 959963;   6: base = 1017046;  7: base = 1077524;
         8: base = 1141599;  9: base = 1209486;  10: base = 1281408; default: base = 1357607;
      endcase
      return base >> (10 - n / 12);
   endfunction

   // 0 none, 1 note-on, 2 note-off, 3 all-off
   function automatic int decode(input logic [7:0] s, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic om);
      if (!om && s[3:0] != 4'(CH)) return 0;
      if (s[7:4] == 4'h9) return (d2 != 0) ? 1 : 2;
      if (s[7:4] == 4'h8) return 2;
      if (s[7:4] == 4'hB && (d1 == 8'd120 || d1 == 8'd123)) return 3;
      return 0;
   endfunction

   function automatic int rank(input int v);
      int r = 0;
      for (int w = 0; w < POLY; w++) if (m_stamp[w] > m_stamp[v]) r++;
      return r;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < POLY; v++) begin
         m_key[v] = 0; m_held[v] = 0; m_note[v] = 0;
         m_freq[v] = 0; m_vel[v] = 0; m_stamp[v] = v;
      end
      next_stamp = POLY;
      rem = 0; commit_in = 0; rise_in = 0;
   endtask

   task automatic plan(input int ev, input int note, input int vel);
      int match = -1, free = -1, oldest = 0;
      for (int v = POLY - 1; v >= 0; v--) begin
         if (m_held[v] && m_note[v] == note) match = v;
         if (!m_held[v]) free = v;
      end
      for (int v = 0; v < POLY; v++) if (m_stamp[v] < m_stamp[oldest]) oldest = v;
      p_ev = ev; p_note = note; p_vel = vel; p_gap = 0; p_tgt = match;
      if (ev == 1) begin
         if (match >= 0)     begin p_tgt = match;  p_gap = 1; end
         else if (free >= 0) begin p_tgt = free;   p_gap = m_key[free]; end
         else                begin p_tgt = oldest; p_gap = 1; end
      end
      commit_in = 2;
      rem       = (ev == 1 && p_gap) ? 2 + GAPC : 2;
      rise_in   = (ev == 1 && p_gap) ? 2 + GAPC : 0;
   endtask

   task automatic commit();
      case (p_ev)
         1: begin
            m_freq[p_tgt] = lookup(p_note); m_vel[p_tgt] = p_vel;
            m_note[p_tgt] = p_note; m_held[p_tgt] = 1;
            m_stamp[p_tgt] = next_stamp; next_stamp++;
            m_key[p_tgt] = !p_gap;
         end
         2: if (p_tgt >= 0) begin m_key[p_tgt] = 0; m_held[p_tgt] = 0; end
         3: for (int v = 0; v < POLY; v++) begin m_key[v] = 0; m_held[v] = 0; end
         default: ;
      endcase
   endtask

   task automatic model_step();
      bit was_busy;
      int ev;
      if (reset) begin
         model_reset();
         armed = 1'b1;
      end else begin
         was_busy = rem > 0;
         if (commit_in > 0) begin commit_in--; if (commit_in == 0) commit(); end
         if (rise_in > 0)   begin rise_in--;   if (rise_in == 0) m_key[p_tgt] = 1; end
         if (rem > 0) rem--;
         if (!was_busy && ready) begin
            ev = decode(b0, b1, b2, omni);
            if (ev != 0) plan(ev, int'(b1 & 8'h7F), int'(b2 & 8'h7F));
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      logic [POLY*FW-1:0] ef;
      logic [POLY*7-1:0]  ev;
      logic [POLY-1:0]    ek, seen;
      logic [POLY*VW-1:0] ea, aa;
      @(negedge clk);
      if (armed) begin
         seen = '0;
         for (int v = 0; v < POLY; v++) begin
            ef[v*FW +: FW] = FW'(m_freq[v]);
            ev[v*7 +: 7]   = 7'(m_vel[v]);
            ek[v]          = m_key[v];
            ea[v*VW +: VW] = VW'(rank(v));
            aa[v*VW +: VW] = dut.age[v];
            seen[dut.age[v]] = 1'b1;
         end
         chk("key_state", key, ek);
         chk("freq_bus", freq_bus, ef);
         chk("vel_bus", vel_bus, ev);
         chk("busy", busy, rem > 0);
         chk("dropped_event", dropped, ready && rem > 0);
         chk("age_perm", seen, {POLY{1'b1}});
         chk("age_lru", aa, ea);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
      ready = 1'b1; b0 = s; b1 = d1; b2 = d2;
      step();
      ready = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 20) begin step(); n++; end
      chk("idle_timeout", busy, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #1;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk("reset_key", key, 8'h00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_freq", freq_bus, '0);

      // First note lands on voice 0 two edges after the strobe.
      send(8'h90, 8'h3C, 8'h64);
      chk("t1_busy_search", busy, 1'b1);
      step();
      chk("t1_busy_apply", busy, 1'b1);
      chk("t1_key_before", key, 8'h00);
      step();
      chk("t1_key", key, 8'h01);
      chk("t1_freq0", freq_bus[31:0], 32'd22473);
      chk("t1_vel0", vel_bus[6:0], 7'd100);
      chk("t1_busy_done", busy, 1'b0);

      // Fill all voices, then steal the oldest (voice 0).
      for (int n = 61; n <= 67; n++) begin
         send(8'h90, 8'(n), 8'h32);
         wait_idle();
      end
      chk("t2_full", key, 8'hFF);
      send(8'h90, 8'd72, 8'h5A);
      step(); step();
      chk("t2_steal_low0", key, 8'hFE);
      chk("t2_freq0", freq_bus[31:0], 32'd44947);
      step();
      chk("t2_steal_low1", key, 8'hFE);
      step();
      chk("t2_steal_rise", key, 8'hFF);

      // Velocity-0 note-on releases; unheld note-off changes nothing.
      do_reset();
      send(8'h90, 8'h3C, 8'h64); wait_idle();
      send(8'h90, 8'h3C, 8'h00); wait_idle();
      chk("t3_key_off", key, 8'h00);
      chk("t3_freq_kept", freq_bus[31:0], 32'd22473);
      send(8'h80, 8'h3D, 8'h40); wait_idle();
      chk("t3_noop", key, 8'h00);

      // Same-note re-strike retriggers voice 0.
      do_reset();
      send(8'h90, 8'h3C, 8'h64); wait_idle();
      send(8'h90, 8'h3C, 8'h28); wait_idle();
      chk("t4_key", key, 8'h01);
      chk("t4_vel0", vel_bus[6:0], 7'd40);

      // Channel filter and all-notes-off.
      do_reset();
      omni = 1'b0;
      send(8'h91, 8'h3C, 8'h64);
      chk("t5_ignored_busy", busy, 1'b0);
      step(); step();
      chk("t5_ignored_key", key, 8'h00);
      omni = 1'b1;
      send(8'h91, 8'h3C, 8'h64); wait_idle();
      chk("t5_omni_key", key, 8'h01);
      send(8'h90, 8'h3E, 8'h64); wait_idle();
      send(8'h90, 8'h40, 8'h64); wait_idle();
      chk("t5_three", key, 8'h07);
      send(8'hB0, 8'd123, 8'h00); wait_idle();
      chk("t5_all_off", key, 8'h00);
      omni = 1'b0;

      // Strobe while busy is dropped; reset during the gap clears everything.
      do_reset();
      send(8'h90, 8'h3C, 8'h64);
      ready = 1'b1; b0 = 8'h90; b1 = 8'h40; b2 = 8'h64;
      #1;
      chk("t6_dropped", dropped, 1'b1);
      @(posedge clk); #1;
      ready = 1'b0;
      wait_idle();
      chk("t6_first_only", key, 8'h01);
      send(8'h90, 8'h3C, 8'h50);
      step(); step();
      chk("t6_in_gap", key, 8'h00);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_reset_key", key, 8'h00);
      chk("t6_reset_freq", freq_bus, '0);
      chk("t6_reset_vel", vel_bus, '0);
      chk("t6_reset_busy", busy, 1'b0);

      // Randomized event stream; the per-cycle compare does the checking.
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] chan;
         int kind;
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 63) == 0) omni = ~omni;
         chan = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(CH);
         if ($urandom_range(0, 99) < 35) begin
            ready = 1'b1;
            kind = $urandom_range(0, 9);
            b1 = 8'(55 + $urandom_range(0, 14));
            b2 = 8'($urandom_range(1, 127));
            if (kind <= 4)      b0 = {4'h9, chan};
            else if (kind == 5) b0 = {4'h8, chan};
            else if (kind == 6) begin b0 = {4'h9, chan}; b2 = 8'h00; end
            else if (kind == 7) begin
               b0 = {4'hB, chan};
               b1 = ($urandom_range(0, 2) == 0) ? 8'd120 : (($urandom_range(0, 1) == 0) ? 8'd123 : 8'd7);
            end else if (kind == 8) b0 = {4'hE, chan};
            else begin
               b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
            end
         end else begin
            ready = 1'b0;
         end
         step();
      end
      reset = 1'b0;
      ready = 1'b0;
      repeat (8) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/poly_voice_allocator.md
Name: poly_voice_allocator

Overview:
- Parametrised successor to the 4-voice MIDI note controller.
- Decodes note-on, note-off and all-notes-off events from the MIDI decoder onto POLYPHONY voices, each with its own frequency word, velocity and gate.
- Tracks which note each voice holds. Same-note re-strikes retrigger that voice; when no voice is free, the least-recently-allocated voice is stolen.
- Feeds the per-voice DDS and ADSR instances.

Parameters:
POLYPHONY  8  number of voices, 2..16
VIDX_W  3  voice index width, >= clog2(POLYPHONY)
FREQ_W  32  tuning word width (tuning_code_lookup output)
RETRIG_GAP  2  cycles key_state is held low on retrigger/steal, >= 1
MIDI_CHANNEL  0  channel accepted when omni=0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
midi_byte_ready  in  1  one-cycle strobe; midi_byte0..2 are valid in this cycle
midi_byte0  in  8  status byte
midi_byte1  in  8  note number / controller number
midi_byte2  in  8  velocity / controller value
omni  in  1  1 = accept all channels
dds_frequency_bus  out  POLYPHONY*FREQ_W  voice v occupies bits [v*FREQ_W +: FREQ_W]
voice_velocity  out  POLYPHONY*7  voice v occupies bits [v*7 +: 7]
key_state  out  POLYPHONY  per-voice gate to ADSR
busy  out  1  high while the FSM is not in IDLE
dropped_event  out  1  one-cycle pulse when a strobe arrives while busy

Behaviour:
- Reset (synchronous, active-high), effective on the next clk edge, including mid-operation:
  - all outputs 0; FSM to IDLE.
  - voice_note[v]=0, voice_held[v]=0.
  - age[v]=POLYPHONY-1-v, so voice 0 is the oldest.
- Decode happens on the IDLE strobe (bytes latched in that cycle):
  - Channel match required: midi_byte0[3:0]==MIDI_CHANNEL, or omni=1.
  - NOTE_ON: status 0x9n with velocity != 0.
  - NOTE_OFF: status 0x8n, or 0x9n with velocity 0.
  - ALL_OFF: status 0xBn with byte1==120 or byte1==123.
  - Anything else, or a channel mismatch: ignored and FSM stays IDLE. Unsupported events never change any output.
- FSM states: IDLE -> SEARCH -> APPLY -> (GAP) -> IDLE.
  - SEARCH (1 cycle): all voices are compared in parallel to find:
    - match: lowest v with voice_held[v] and voice_note[v]==note.
    - free: lowest v with !voice_held[v].
    - oldest: v with age[v]==POLYPHONY-1.
  - APPLY, NOTE_ON: target = match if found, else free if found, else oldest.
    - Write dds_frequency_bus[target] = tuning_code_lookup(note), voice_velocity[target] = byte2[6:0], voice_note[target]=note, voice_held[target]=1.
    - Age update: every voice with age < age[target] increments; age[target]=0.
    - If the target was free and its key_state is 0: key_state[target]=1 now, then IDLE.
    - Otherwise (match, steal, or a still-releasing gate): key_state[target]=0, go to GAP.
  - GAP: count RETRIG_GAP cycles with key_state low, then set key_state[target]=1 and go to IDLE.
  - APPLY, NOTE_OFF: if match, key_state[match]=0 and voice_held[match]=0. Frequency and velocity are retained for the release phase. No match means no effect. Then IDLE.
  - APPLY, ALL_OFF: all key_state and voice_held cleared. Then IDLE.
- Latency:
  - Strobe at cycle T: outputs change at edge T+2.
  - Retriggered gate rises at T+2+RETRIG_GAP.
  - busy is high from T+1 until the FSM returns to IDLE.
- Strobe while busy:
  - The event is dropped and dropped_event pulses in the same cycle.
  - State is unchanged and no queueing is performed.
- Duplicate NOTE_ON for a held note reuses that voice; it never occupies two voices.
- Ages always form a permutation of 0..POLYPHONY-1, with no wrap-around. The bench checks this invariant every cycle.

Test Plan:
- Reset, then NOTE_ON ch0 note 60 vel 100 (0x90,0x3C,0x64) at T -> at T+2 key_state=0x01, freq[0]=lookup(60), vel[0]=100; busy high for 2 cycles.
- Notes 60..67 on 8 voices, then note 72 -> voice 0 (oldest) stolen: key_state[0] 0 for 2 cycles then 1, freq[0]=lookup(72); key_state ends 0xFF.
- Note 60 on, then 0x90,0x3C,0x00 -> key_state[0]=0, freq[0] still lookup(60); 0x80 with note 61 (not held) -> no output change.
- Note 60 on, then note 60 again vel 40 -> same voice 0 drops for RETRIG_GAP then rises, vel[0]=40; key_state bit 1 never set.
- omni=0, MIDI_CHANNEL=0, 0x91 note 60 -> ignored; omni=1 -> accepted. 0xB0,123,0 with 3 voices held -> key_state=0.
- Strobe at T+1 after an accepted event -> dropped_event pulses at T+1, outputs reflect only the first event; reset asserted during GAP -> all outputs 0 next edge.
